// File: rtl/l2arb_pkg.sv
// rtl/l2arb_pkg.sv - shared source codes and FSM state type for the L2 request arbiter
// Contents: SRC_* owner/source encodings (also driven on arb_l2_src), arb_state_t FSM states.
package l2arb_pkg;

    localparam logic [1:0] SRC_I    = 2'd0;
    localparam logic [1:0] SRC_D    = 2'd1;
    localparam logic [1:0] SRC_P    = 2'd2;
    localparam logic [1:0] SRC_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/l2_arb_rr_pick.sv
// rtl/l2_arb_rr_pick.sv - two-way round-robin picker between I and D requests
// Ports: req_i/req_d eligible requests, rr_last (0: I won last, 1: D won last), gnt_i/gnt_d one-hot grant.
module l2_arb_rr_pick (
    input  logic req_i,
    input  logic req_d,
    input  logic rr_last,
    output logic gnt_i,
    output logic gnt_d
);

    // On a tie the side that did not win last time is granted.
    assign gnt_i = req_i & (~req_d | rr_last);
    assign gnt_d = req_d & (~req_i | ~rr_last);

endmodule

// File: rtl/l2_req_arbiter.sv
// rtl/l2_req_arbiter.sv - shares the single L2 request port between I refill, D access and prefetch
// Ports: clk/rst (sync, active-high); icache_* I refill request + flush; dcache_* D read/write request;
//        pref_* prefetch request; arb_*_addrOK/dataOK/done per-source handshakes; arb_l1_data response line;
//        arb_l2_* latched request to L2; l2_arb_* L2 handshake and data; arb_busy = transaction in flight.
module l2_req_arbiter
    import l2arb_pkg::*;
#(
    parameter int  L1_offset_width = 2,
    parameter bit  PREF_EN         = 1'b1,
    localparam int LINE_W          = 32 << L1_offset_width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_arb_req,
    input  logic [31:0]       icache_arb_addr,
    input  logic              icache_arb_SUC,
    input  logic              icache_flush,
    output logic              arb_icache_addrOK,
    output logic              arb_icache_dataOK,
    input  logic              dcache_arb_req,
    input  logic              dcache_arb_wr,
    input  logic [31:0]       dcache_arb_addr,
    input  logic [31:0]       dcache_arb_pc,
    input  logic [31:0]       dcache_arb_din,
    input  logic [3:0]        dcache_arb_wstrb,
    input  logic              dcache_arb_SUC,
    output logic              arb_dcache_addrOK,
    output logic              arb_dcache_dataOK,
    input  logic              pref_arb_req,
    input  logic              pref_arb_type,
    input  logic [31:0]       pref_arb_addr,
    output logic              arb_pref_addrOK,
    output logic              arb_pref_done,
    output logic [LINE_W-1:0] arb_l1_data,
    output logic              arb_l2_req,
    output logic [1:0]        arb_l2_src,
    output logic [31:0]       arb_l2_addr,
    output logic [31:0]       arb_l2_pc,
    output logic [31:0]       arb_l2_din,
    output logic              arb_l2_wr,
    output logic              arb_l2_SUC,
    output logic              arb_l2_ptype,
    output logic [3:0]        arb_l2_wstrb,
    input  logic              l2_arb_addrOK,
    input  logic              l2_arb_dataOK,
    input  logic [LINE_W-1:0] l2_arb_data,
    output logic              arb_busy
);

    arb_state_t  r_state;
    logic [1:0]  r_owner;
    logic        r_rr_last;   // 0: I won the last I/D grant, 1: D did
    logic        r_kill;      // owner I was flushed; swallow its response
    logic [1:0]  r_src;
    logic [31:0] r_addr;
    logic [31:0] r_pc;
    logic [31:0] r_din;
    logic [3:0]  r_wstrb;
    logic        r_wr;
    logic        r_suc;
    logic        r_ptype;

    logic w_idle;
    logic w_req_i_ok;
    logic w_rr_gnt_i;
    logic w_rr_gnt_d;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_gnt_p;
    logic w_grant;
    logic w_done;

    assign w_idle     = (r_state == IDLE);
    assign w_req_i_ok = icache_arb_req & ~icache_flush;

    l2_arb_rr_pick u_rr_pick (
        .req_i   (w_req_i_ok),
        .req_d   (dcache_arb_req),
        .rr_last (r_rr_last),
        .gnt_i   (w_rr_gnt_i),
        .gnt_d   (w_rr_gnt_d)
    );

    assign w_gnt_i = w_idle & w_rr_gnt_i;
    assign w_gnt_d = w_idle & w_rr_gnt_d;
    // Prefetch yields to any raw L1 request, even an I request masked by flush.
    assign w_gnt_p = w_idle & PREF_EN & pref_arb_req & ~icache_arb_req & ~dcache_arb_req;
    assign w_grant = w_gnt_i | w_gnt_d | w_gnt_p;

    // Completion: dataOK in WAIT, or addrOK and dataOK together while still in REQ.
    assign w_done = ((r_state == WAIT) & l2_arb_dataOK)
                  | ((r_state == REQ) & l2_arb_addrOK & l2_arb_dataOK);

    assign arb_icache_addrOK = w_gnt_i;
    assign arb_dcache_addrOK = w_gnt_d;
    assign arb_pref_addrOK   = w_gnt_p;
    assign arb_icache_dataOK = w_done & (r_owner == SRC_I) & ~(r_kill | icache_flush);
    assign arb_dcache_dataOK = w_done & (r_owner == SRC_D);
    assign arb_pref_done     = w_done & (r_owner == SRC_P);
    assign arb_l1_data       = (arb_icache_dataOK | arb_dcache_dataOK) ? l2_arb_data : '0;

    assign arb_l2_req   = (r_state == REQ);
    assign arb_busy     = ~w_idle;
    assign arb_l2_src   = r_src;
    assign arb_l2_addr  = r_addr;
    assign arb_l2_pc    = r_pc;
    assign arb_l2_din   = r_din;
    assign arb_l2_wstrb = r_wstrb;
    assign arb_l2_wr    = r_wr;
    assign arb_l2_SUC   = r_suc;
    assign arb_l2_ptype = r_ptype;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_owner   <= SRC_NONE;
            r_rr_last <= 1'b0;
            r_kill    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) r_state <= REQ;
                    if (w_gnt_i) begin
                        r_owner   <= SRC_I;
                        r_rr_last <= 1'b0;
                    end else if (w_gnt_d) begin
                        r_owner   <= SRC_D;
                        r_rr_last <= 1'b1;
                    end else if (w_gnt_p) begin
                        r_owner   <= SRC_P;
                    end
                end
                REQ, WAIT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_owner <= SRC_NONE;
                        r_kill  <= 1'b0;
                    end else begin
                        if ((r_state == REQ) && l2_arb_addrOK) r_state <= WAIT;
                        // The L2 handshake still runs to completion; only the I response is dropped.
                        if ((r_owner == SRC_I) && icache_flush) r_kill <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Request capture bank: fields not used by the winning source are zeroed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src   <= 2'd0;
            r_addr  <= 32'd0;
            r_pc    <= 32'd0;
            r_din   <= 32'd0;
            r_wstrb <= 4'd0;
            r_wr    <= 1'b0;
            r_suc   <= 1'b0;
            r_ptype <= 1'b0;
        end else if (w_grant) begin
            r_pc    <= 32'd0;
            r_din   <= 32'd0;
            r_wstrb <= 4'd0;
            r_wr    <= 1'b0;
            r_suc   <= 1'b0;
            r_ptype <= 1'b0;
            if (w_gnt_i) begin
                r_src  <= SRC_I;
                r_addr <= icache_arb_addr;
                r_suc  <= icache_arb_SUC;
            end else if (w_gnt_d) begin
                r_src   <= SRC_D;
                r_addr  <= dcache_arb_addr;
                r_pc    <= dcache_arb_pc;
                r_din   <= dcache_arb_din;
                r_wstrb <= dcache_arb_wstrb;
                r_wr    <= dcache_arb_wr;
                r_suc   <= dcache_arb_SUC;
            end else begin
                r_src   <= SRC_P;
                r_addr  <= pref_arb_addr;
                r_ptype <= pref_arb_type;
            end
        end
    end

endmodule
